ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync_edge.sv | 38 +++
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common command bytes, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StInhibit  = 3'd1,
    StRequest  = 3'd2,
    StShift    = 3'd3,
    StAck      = 3'd4,
    StWaitIdle = 3'd5
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // PS/2 uses odd parity: data plus parity bit carry an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a clock falling-edge strobe.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_data_meta;
  logic r_data_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_meta  <= 1'b0;
      r_clk_sync  <= 1'b0;
      r_clk_prev  <= 1'b0;
      r_data_meta <= 1'b0;
      r_data_sync <= 1'b0;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  assign o_clk_sync  = r_clk_sync;
  assign o_data_sync = r_data_sync;
  assign o_clk_fall  = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift 8 data + parity + stop, check ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned    InhW     = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [19:0]    ToLimit  = 20'(TIMEOUT_CYCLES);
  localparam logic [19:0]    ToMax    = 20'hF_FFFF;

  ps2_state_e      r_state, w_state_d;
  logic [InhW-1:0] r_inh_cnt, w_inh_cnt_d;
  logic [3:0]      r_edge_cnt, w_edge_cnt_d;
  logic [19:0]     r_to_cnt, w_to_cnt_d;
  logic [8:0]      r_shift, w_shift_d;
  logic            r_data_oe, w_data_oe_d;
  logic            r_tx_done, w_tx_done_d;
  logic            r_tx_error, w_tx_error_d;

  logic       w_clk_sync;
  logic       w_data_sync;
  logic       w_clk_fall;
  logic       w_active;
  logic       w_timeout;
  logic [3:0] w_edge_next;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .reset       (reset),
    .i_ps2_clk   (ps2_clk_in),
    .i_ps2_data  (ps2_data_in),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_clk_fall  (w_clk_fall)
  );

  assign w_active    = (r_state == StRequest) || (r_state == StShift) || (r_state == StAck);
  assign w_timeout   = w_active && (r_to_cnt >= ToLimit);
  assign w_edge_next = r_edge_cnt + 4'd1;

  always_comb begin
    w_state_d    = r_state;
    w_inh_cnt_d  = r_inh_cnt;
    w_edge_cnt_d = r_edge_cnt;
    w_shift_d    = r_shift;
    w_data_oe_d  = r_data_oe;
    w_tx_done_d  = 1'b0;
    w_tx_error_d = 1'b0;

    if (w_active) begin
      w_to_cnt_d = (r_to_cnt == ToMax) ? r_to_cnt : r_to_cnt + 20'd1;
    end else begin
      w_to_cnt_d = '0;
    end

    unique case (r_state)
      StIdle: begin
        if (tx_start) begin
          w_shift_d   = {ps2_odd_parity(tx_data), tx_data};
          w_inh_cnt_d = '0;
          w_state_d   = StInhibit;
        end
      end
      StInhibit: begin
        if (r_inh_cnt == InhLast) begin
          w_edge_cnt_d = '0;
          w_state_d    = StRequest;
        end else begin
          w_inh_cnt_d = r_inh_cnt + 1'b1;
        end
      end
      StRequest: begin
        w_data_oe_d = 1'b1;
        w_state_d   = StShift;
      end
      StShift: begin
        // Edges 1..9 put out data LSB first then parity; edge 10 frees the line for stop.
        if (w_clk_fall) begin
          w_edge_cnt_d = w_edge_next;
          if (w_edge_next == 4'd10) begin
            w_data_oe_d = 1'b0;
            w_state_d   = StAck;
          end else begin
            w_data_oe_d = ~r_shift[0];
            w_shift_d   = {1'b0, r_shift[8:1]};
          end
        end
      end
      StAck: begin
        w_data_oe_d = 1'b0;
        if (w_clk_fall) begin
          w_edge_cnt_d = w_edge_next;
          w_tx_done_d  = ~w_data_sync;
          w_tx_error_d = w_data_sync;
          w_state_d    = StWaitIdle;
        end
      end
      StWaitIdle: begin
        w_data_oe_d = 1'b0;
        if (w_clk_sync && w_data_sync) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_timeout) begin
      w_data_oe_d  = 1'b0;
      w_tx_done_d  = 1'b0;
      w_tx_error_d = 1'b1;
      w_state_d    = StWaitIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_inh_cnt  <= '0;
      r_edge_cnt <= '0;
      r_to_cnt   <= '0;
      r_shift    <= '0;
      r_data_oe  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_inh_cnt  <= w_inh_cnt_d;
      r_edge_cnt <= w_edge_cnt_d;
      r_to_cnt   <= w_to_cnt_d;
      r_shift    <= w_shift_d;
      r_data_oe  <= w_data_oe_d;
      r_tx_done  <= w_tx_done_d;
      r_tx_error <= w_tx_error_d;
    end
  end

  // Line drives decode straight from state so an async reset frees the bus immediately.
  assign ps2_clk_oe  = (r_state == StInhibit);
  assign ps2_data_oe = ((r_state == StInhibit) && (r_inh_cnt == InhLast)) ||
                       (r_state == StRequest) ||
                       ((r_state == StShift) && r_data_oe);
  assign busy        = (r_state != StIdle);
  assign tx_done     = r_tx_done;
  assign tx_error    = r_tx_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model, PS/2 device model, queue scoreboard.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_rel = 1'b1;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_error;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk_rel;
  assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  typedef struct {
    logic [10:0] frame;
    bit          chk_frame;
    bit          exp_done;
    bit          timeout;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  int          pushed = 0;
  int          cyc = 0;
  int          run = 0;
  int          inh_len = 0;
  int          req_cyc = 0;
  logic [10:0] cap_frame = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame as the device sees it on rising edges: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      if (d[i]) ones++;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Monitor: measures inhibit length / request time, pops the scoreboard on every result pulse.
  always @(negedge clk) begin
    cyc++;
    if (ps2_clk_oe) begin
      run++;
    end else if (run > 0) begin
      inh_len = run;
      run     = 0;
      req_cyc = cyc;
    end
    if (tx_done || tx_error) begin
      pulses++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b, wanted none", tx_done, tx_error);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {30'b0, tx_done, tx_error}, mon_e.exp_done ? 32'd2 : 32'd1);
        check("inhibit_len", inh_len, INH);
        if (mon_e.chk_frame) check("frame_bits", {21'b0, cap_frame}, {21'b0, mon_e.frame});
        if (mon_e.timeout) begin
          total++;
          if ((cyc - req_cyc) < TMO || (cyc - req_cyc) > TMO + 2) begin
            bad++;
            $display("FAIL timeout_latency: got %0d, wanted %0d..%0d", cyc - req_cyc, TMO, TMO + 2);
          end
          check("timeout_oe_released", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        end
      end
    end
  end

  // Device: waits for request-to-send, clocks the frame, optionally acks on edge 11.
  task automatic dev_frame(input bit ack, input int abort_at);
    int t = 0;
    while (!(ps2_clk_in && !ps2_data_in) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("request_seen", {31'b0, t < 2000}, 32'd1);
    if (t >= 2000) return;
    cap_frame    = '0;
    cap_frame[0] = ps2_data_in;
    repeat (HALF) @(negedge clk);
    for (int e = 1; e <= 11; e++) begin
      dev_clk_rel = 1'b0;
      if (e == abort_at) begin
        repeat (10) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      if (e <= 10) cap_frame[e] = ps2_data_in;
      dev_clk_rel = 1'b1;
      if (e == 10 && ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while (busy && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("busy_fall", {31'b0, busy}, 32'd0);
    check("lines_idle", {30'b0, ps2_clk_in, ps2_data_in}, 32'd3);
  endtask

  task automatic do_txn(input logic [7:0] d, input bit ack, input bit restart);
    exp_t e;
    e.frame     = ref_frame(d);
    e.chk_frame = 1'b1;
    e.exp_done  = ack;
    e.timeout   = 1'b0;
    exp_q.push_back(e);
    pushed++;
    send(d);
    if (restart) begin
      fork
        dev_frame(ack, 0);
        begin
          repeat (300) @(negedge clk);
          tx_data  = ~d;
          tx_start = 1'b1;
          @(negedge clk);
          tx_start = 1'b0;
          tx_data  = d;
        end
      join
    end else begin
      dev_frame(ack, 0);
    end
    wait_idle(500);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [7:0] d;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done_err", {30'b0, tx_done, tx_error}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    do_txn(8'hED, 1'b1, 1'b0);
    do_txn(8'h00, 1'b1, 1'b0);
    do_txn(8'h07, 1'b1, 1'b0);
    do_txn(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      do_txn(d, ($urandom_range(0, 3) != 0), 1'b0);
    end
    do_txn(8'h3C, 1'b1, 1'b1);

    // Device never clocks: expect a timeout error.
    e.frame     = '0;
    e.chk_frame = 1'b0;
    e.exp_done  = 1'b0;
    e.timeout   = 1'b1;
    exp_q.push_back(e);
    pushed++;
    send(8'h55);
    wait_idle(TMO + 500);
    repeat (5) @(negedge clk);

    // Reset in the middle of the frame, just after edge 5 drives bit 4 (= 0) of 8'hE5.
    send(8'hE5);
    dev_frame(1'b1, 5);
    check("abort_pre_data_oe", {31'b0, ps2_data_oe}, 32'd1);
    #3 reset = 1'b1;
    #1 check("abort_oe_released", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    dev_clk_rel  = 1'b1;
    dev_data_low = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_idle", {31'b0, busy}, 32'd0);

    repeat (100) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("pulse_count", pulses, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
